// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the memory stage and a word-only data RAM.
// Sub-word stores use read-modify-write; loads get lane select and extension.
module dmem_ctrl #(
  parameter int SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_WR,
    RMW_RD, RMW_WR, RESP
  } state_e;

  localparam logic [31:0] LIMIT = 32'(SIZE * 4);

  state_e      state_q, state_d;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_addr_q;

  logic        accept;
  logic        illegal;
  logic        misal;
  logic        oor;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

  assign misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
              || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign oor     = (req_addr >= LIMIT);
  assign req_err = illegal || misal || oor;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = RESP;
          else if (!req_we)            state_d = LD_RD;
          else if (req_funct3 == 3'b010) state_d = ST_WR;
          else                         state_d = RMW_RD;
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP:  state_d = RESP;
      ST_WR:   state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = ram_rd[7:0];
    unique case (lane_q)
      2'd0: byte_sel = ram_rd[7:0];
      2'd1: byte_sel = ram_rd[15:8];
      2'd2: byte_sel = ram_rd[23:16];
      2'd3: byte_sel = ram_rd[31:24];
      default: byte_sel = ram_rd[7:0];
    endcase
    half_sel = lane_q[1] ? ram_rd[31:16] : ram_rd[15:0];
  end

  always_comb begin
    ld_ext = ram_rd;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = ram_rd;
    endcase
  end

  // Only the addressed lane(s) change; the rest come from the fresh read.
  always_comb begin
    merged = ram_rd;
    if (f3_q[0]) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_rd;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q     <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
    end else begin
      if (accept) begin
        lane_q  <= req_addr[1:0];
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        if (req_err) rdata_q <= '0;
        else         ram_addr_q <= {req_addr[31:2], 2'b00};
      end
      if (state_q == LD_CAP) rdata_q <= ld_ext;
    end
  end

  always_comb begin
    ram_wd = '0;
    if (state_q == ST_WR)  ram_wd = wdata_q;
    if (state_q == RMW_WR) ram_wd = merged;
  end

  // Gated by rst so an abandoned transaction never writes or responds.
  assign ram_we = !rst && ((state_q == ST_WR) || (state_q == RMW_WR));
  assign rsp_valid = !rst && (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign req_ready = (state_q == IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table over a behavioural word RAM,
// plus a reset-during-RMW sequence.
module tb_dmem_ctrl;

  localparam int SIZE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  logic [31:0] mem [SIZE];

  int checks = 0;
  int failures = 0;
  logic [31:0] prev_rd;

  always #5 clk = ~clk;

  dmem_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_wd;
    ram_rd <= mem[ram_addr[7:2]];
  end

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  lat;
    logic [3:0]  wecyc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string name);
    int cyc;
    int we_cnt;
    int we_at;
    int waited;
    logic busy_ok;
    logic [31:0] exp_rd;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wd;
    req_valid  = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    cyc = 0;
    we_cnt = 0;
    we_at = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (req_ready) busy_ok = 1'b0;
      if (ram_we) begin
        we_cnt++;
        we_at = cyc;
      end
    end while (!rsp_valid && cyc < 12);
    if (v.err)     exp_rd = 32'd0;
    else if (v.we) exp_rd = prev_rd;
    else           exp_rd = v.rd;
    chk({name, "_lat"}, cyc, {28'd0, v.lat});
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, v.err});
    chk({name, "_rdata"}, rsp_rdata, exp_rd);
    chk({name, "_wecnt"}, we_cnt, (v.wecyc != 0) ? 1 : 0);
    chk({name, "_wecyc"}, we_at, {28'd0, v.wecyc});
    chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    prev_rd = exp_rd;
  endtask

  initial begin
    int seen_v;
    int seen_we;
    for (int i = 0; i < SIZE; i++) mem[i] = 32'd0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    prev_rd = 32'd0;

    //           we  f3     addr     wdata         err rdata         lat wecyc
    vecs.push_back('{1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1});
    vecs.push_back('{0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 3, 0});
    vecs.push_back('{1, 3'b000, 32'h12, 32'h00000055, 0, 32'h0,        3, 2});
    vecs.push_back('{0, 3'b010, 32'h10, 32'h0,        0, 32'hDE55BEEF, 3, 0});
    vecs.push_back('{0, 3'b000, 32'h12, 32'h0,        0, 32'h00000055, 3, 0});
    vecs.push_back('{0, 3'b100, 32'h13, 32'h0,        0, 32'h000000DE, 3, 0});
    vecs.push_back('{0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFDE, 3, 0});
    vecs.push_back('{0, 3'b000, 32'h10, 32'h0,        0, 32'hFFFFFFEF, 3, 0});
    vecs.push_back('{0, 3'b101, 32'h10, 32'h0,        0, 32'h0000BEEF, 3, 0});
    vecs.push_back('{1, 3'b001, 32'h16, 32'h12348001, 0, 32'h0,        3, 2});
    vecs.push_back('{0, 3'b010, 32'h14, 32'h0,        0, 32'h80010000, 3, 0});
    vecs.push_back('{0, 3'b001, 32'h16, 32'h0,        0, 32'hFFFF8001, 3, 0});
    vecs.push_back('{0, 3'b101, 32'h16, 32'h0,        0, 32'h00008001, 3, 0});
    vecs.push_back('{0, 3'b001, 32'h14, 32'h0,        0, 32'h00000000, 3, 0});
    vecs.push_back('{0, 3'b010, 32'h11, 32'h0,        1, 32'h0,        1, 0});
    vecs.push_back('{1, 3'b001, 32'h13, 32'hFFFFFFFF, 1, 32'h0,        1, 0});
    vecs.push_back('{1, 3'b010, 32'h100, 32'h11111111, 1, 32'h0,       1, 0});
    vecs.push_back('{1, 3'b100, 32'h10, 32'h22222222, 1, 32'h0,        1, 0});
    vecs.push_back('{0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        1, 0});
    vecs.push_back('{0, 3'b010, 32'h10, 32'h0,        0, 32'hDE55BEEF, 3, 0});
    vecs.push_back('{1, 3'b000, 32'hFF, 32'h000000AA, 0, 32'h0,        3, 2});
    vecs.push_back('{0, 3'b100, 32'hFF, 32'h0,        0, 32'h000000AA, 3, 0});
    vecs.push_back('{0, 3'b010, 32'hFC, 32'h0,        0, 32'hAA000000, 3, 0});
    vecs.push_back('{0, 3'b000, 32'h100, 32'h0,       1, 32'h0,        1, 0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wd", ram_wd, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // req_valid stays high across the whole table: back-to-back issue.
    for (int i = 0; i < vecs.size(); i++)
      run_req(vecs[i], $sformatf("v%0d", i));
    req_valid = 1'b0;
    seen_v = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen_v++;
    end
    chk("no_stale_rsp", seen_v, 0);

    // Reset during RMW_RD of a byte store abandons it.
    req_we = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h10;
    req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_rd_we", {31'd0, ram_we}, 32'd0);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_we", {31'd0, ram_we}, 32'd0);
    chk("rstmid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    prev_rd = 32'd0;
    seen_v = 0;
    seen_we = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen_v++;
      if (ram_we) seen_we++;
    end
    chk("rstmid_no_rsp", seen_v, 0);
    chk("rstmid_no_we", seen_we, 0);
    chk("rstmid_ready2", {31'd0, req_ready}, 32'd1);
    run_req('{0, 3'b010, 32'h10, 32'h0, 0, 32'hDE55BEEF, 3, 0}, "post_rst");
    req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
